mul_urate_gen: RTL
==================

Name: mul_urate_gen

Overview:
- Unary-rate multiplier stream generator, one per PE. It sits directly upstream of the PE accumulator.
- Captures a sign-magnitude input/weight pair and emits a 2^MAG_W-cycle product bitstream, plus the control strobes (en, clr, acc, signs) that the accumulator consumes.
- Rate coding uses two bit-reversed (low-discrepancy) counters, so the product count is deterministic.

Parameters:
- MAG_W, 7, magnitude bits per operand; stream length N = 2^MAG_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  load operands and begin a stream
- clr_i  in  1  synchronous abort / clear request
- sign_i_i  in  1  input sign
- sign_w_i  in  1  weight sign
- mag_i_i  in  MAG_W  input magnitude
- mag_w_i  in  MAG_W  weight magnitude
- ready_o  out  1  idle, start_i will be accepted
- en_o  out  1  product bit valid, to accumulator en
- acc_o  out  1  first bit of stream, to accumulator acc
- clr_o  out  1  clear strobe, to accumulator clr
- sign_i_o  out  1  captured input sign
- sign_w_o  out  1  captured weight sign
- prod_bit_o  out  1  product bitstream
- done_o  out  1  one-cycle pulse with the last product bit

Behaviour:
- Reset: clk is the clock; rst_n is asynchronous, active-low.
  - State IDLE; all counters and operand registers 0.
  - All outputs 0 except ready_o=1.
  - Reset mid-stream aborts immediately; no done_o.
- States:
  - IDLE: ready_o=1. start_i=1 captures signs and magnitudes, clears cnt_i and cnt_w, and goes to RUN.
  - RUN: ready_o=0. Runs N cycles indexed k=0..N-1 by cnt_i. After k=N-1, returns to IDLE.
- Bit generation in RUN, combinational then registered:
  - ibit = (mag_i > bitrev(cnt_i)).
  - wbit = (mag_w > bitrev(cnt_w)).
  - prod = ibit & wbit.
  - cnt_i increments every RUN cycle.
  - cnt_w increments only when ibit=1.
  - bitrev reverses all MAG_W bits.
- Output timing: start accepted in cycle T.
  - en_o=1 in cycles T+2..T+N+1.
  - prod_bit_o carries bit k in cycle T+2+k.
  - acc_o=1 only in T+2.
  - done_o=1 only in T+N+1.
  - ready_o returns to 1 in T+N+1.
  - en_o=0, acc_o=0, prod_bit_o=0 whenever not streaming.
- sign_i_o and sign_w_o are updated at capture and held stable until the next capture.
- Exactness:
  - Over a full stream, the count of ibit ones equals mag_i exactly.
  - The prod count equals the number of k < mag_i with bitrev(k) < mag_w.
- Back-to-back: start_i in T+N+1 is accepted; the next en_o rises at T+N+3, leaving a one-cycle gap.
- start_i while in RUN is ignored and not queued.
- clr_i in any state:
  - Next state is IDLE; counters are cleared.
  - clr_o=1 in the following cycle (one cycle per clr_i cycle).
  - en_o, acc_o, prod_bit_o and done_o are forced to 0 from that cycle onward.
- clr_i and start_i in the same cycle: clr wins and start is dropped.
- Magnitude 0 on either operand gives prod_bit_o all 0 while en_o is still high for N cycles.

Optional Feature:
- MUL_UR_EARLY_TERM_EN
- Defined:
  - Adds input len_i (MAG_W+1 bits, captured at start). Valid range is 1..N.
  - RUN ends after k = len-1: en_o lasts len cycles and done_o is on the last of them.
  - len_i=0 is treated as N.
- Undefined: no len_i port; the stream is always N cycles.

Test Plan:
- Reset, then start with mag_i=64, mag_w=64, signs 0/1, MAG_W=7 -> en_o high for exactly 128 cycles starting 2 cycles after start; acc_o only on the first; done_o on the last; prod ones = 32; sign_w_o=1.
- mag_i=127, mag_w=0 -> en_o high for 128 cycles; prod_bit_o ones = 0. Separately, counting ibit through a bench probe gives 127.
- clr_i asserted 10 cycles into RUN -> clr_o pulse next cycle; en_o=0 thereafter; ready_o=1; no done_o.
- start_i and clr_i in the same IDLE cycle -> no stream, clr_o pulse, ready_o stays 1. Also start_i pulsed mid-RUN -> ignored, stream length unchanged.
- start_i on the cycle done_o rises -> second stream accepted; exactly one idle cycle between the two en_o windows; second operands used.
- rst_n dropped mid-stream -> outputs 0 and ready_o=1 immediately (asynchronous); a fresh start afterwards gives the correct count. With MUL_UR_EARLY_TERM_EN, len_i=16 -> en_o high for 16 cycles.

Source files
------------

// File: rtl/mul_urate_gen_if.sv
// Operand/stream bundle between a PE operand feeder (master) and mul_urate_gen (slave).
// Carries len_i only when MUL_UR_EARLY_TERM_EN is defined.
interface mul_urate_gen_if #(
    parameter int unsigned MAG_W = 7
);
    logic             start_i;
    logic             clr_i;
    logic             sign_i_i;
    logic             sign_w_i;
    logic [MAG_W-1:0] mag_i_i;
    logic [MAG_W-1:0] mag_w_i;
`ifdef MUL_UR_EARLY_TERM_EN
    logic [MAG_W:0]   len_i;
`endif
    logic             ready_o;
    logic             en_o;
    logic             acc_o;
    logic             clr_o;
    logic             sign_i_o;
    logic             sign_w_o;
    logic             prod_bit_o;
    logic             done_o;

    modport master (
        output start_i, clr_i, sign_i_i, sign_w_i, mag_i_i, mag_w_i,
`ifdef MUL_UR_EARLY_TERM_EN
        output len_i,
`endif
        input  ready_o, en_o, acc_o, clr_o, sign_i_o, sign_w_o, prod_bit_o, done_o
    );

    modport slave (
        input  start_i, clr_i, sign_i_i, sign_w_i, mag_i_i, mag_w_i,
`ifdef MUL_UR_EARLY_TERM_EN
        input  len_i,
`endif
        output ready_o, en_o, acc_o, clr_o, sign_i_o, sign_w_o, prod_bit_o, done_o
    );
endinterface

// File: rtl/mul_urate_gen.sv
// Unary-rate multiplier stream generator feeding one PE accumulator.
// Optional MUL_UR_EARLY_TERM_EN: stream length taken from len_i (0 means full length).
module mul_urate_gen #(
    parameter int unsigned MAG_W = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mul_urate_gen_if.slave        bus
);
    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           r_state;
    logic [MAG_W-1:0] r_mag_i;
    logic [MAG_W-1:0] r_mag_w;
    logic [MAG_W-1:0] r_cnt_i;
    logic [MAG_W-1:0] r_cnt_w;
    logic             r_sign_i;
    logic             r_sign_w;
    logic             r_ready;
    logic             r_en;
    logic             r_acc;
    logic             r_clr;
    logic             r_prod;
    logic             r_done;

    logic [MAG_W-1:0] w_rev_i;
    logic [MAG_W-1:0] w_rev_w;
    logic             w_ibit;
    logic             w_wbit;
    logic [MAG_W-1:0] w_last_k;
    logic             w_last;

`ifdef MUL_UR_EARLY_TERM_EN
    logic [MAG_W-1:0] r_last;
    assign w_last_k = r_last;
`else
    assign w_last_k = '1;
`endif

    always_comb begin
        w_rev_i = '0;
        w_rev_w = '0;
        for (int b = 0; b < int'(MAG_W); b++) begin
            w_rev_i[b] = r_cnt_i[int'(MAG_W) - 1 - b];
            w_rev_w[b] = r_cnt_w[int'(MAG_W) - 1 - b];
        end
    end

    // Weight counter only advances on input ones, so the product count stays exact.
    assign w_ibit = (r_mag_i > w_rev_i);
    assign w_wbit = (r_mag_w > w_rev_w);
    assign w_last = (r_cnt_i == w_last_k);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_mag_i  <= '0;
            r_mag_w  <= '0;
            r_cnt_i  <= '0;
            r_cnt_w  <= '0;
            r_sign_i <= 1'b0;
            r_sign_w <= 1'b0;
            r_ready  <= 1'b1;
            r_en     <= 1'b0;
            r_acc    <= 1'b0;
            r_clr    <= 1'b0;
            r_prod   <= 1'b0;
            r_done   <= 1'b0;
`ifdef MUL_UR_EARLY_TERM_EN
            r_last   <= '0;
`endif
        end else begin
            r_clr  <= bus.clr_i;
            r_en   <= 1'b0;
            r_acc  <= 1'b0;
            r_prod <= 1'b0;
            r_done <= 1'b0;
            if (bus.clr_i) begin
                r_state <= StIdle;
                r_ready <= 1'b1;
                r_cnt_i <= '0;
                r_cnt_w <= '0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (bus.start_i) begin
                            r_mag_i  <= bus.mag_i_i;
                            r_mag_w  <= bus.mag_w_i;
                            r_sign_i <= bus.sign_i_i;
                            r_sign_w <= bus.sign_w_i;
                            r_cnt_i  <= '0;
                            r_cnt_w  <= '0;
                            r_ready  <= 1'b0;
                            r_state  <= StRun;
`ifdef MUL_UR_EARLY_TERM_EN
                            // len 0 wraps to all-ones, i.e. a full-length stream.
                            r_last   <= bus.len_i[MAG_W-1:0] - 1'b1;
`endif
                        end
                    end
                    StRun: begin
                        r_en    <= 1'b1;
                        r_acc   <= (r_cnt_i == '0);
                        r_prod  <= w_ibit & w_wbit;
                        r_cnt_i <= r_cnt_i + 1'b1;
                        if (w_ibit) begin
                            r_cnt_w <= r_cnt_w + 1'b1;
                        end
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_ready <= 1'b1;
                            r_cnt_i <= '0;
                            r_cnt_w <= '0;
                            r_state <= StIdle;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign bus.ready_o    = r_ready;
    assign bus.en_o       = r_en;
    assign bus.acc_o      = r_acc;
    assign bus.clr_o      = r_clr;
    assign bus.sign_i_o   = r_sign_i;
    assign bus.sign_w_o   = r_sign_w;
    assign bus.prod_bit_o = r_prod;
    assign bus.done_o     = r_done;
endmodule
